key_search_ctrl: RTL and testbench
==================================

// Module: key_search_ctrl
// PURPOSE
//  Brute-force RC4 key search controller; sits upstream of the datapath controller and drives its secret_key.
//  Per candidate: launches one decrypt, waits for done, then scans decrypted memory for printable bytes.
//  Stops on the first key whose whole message passes the scan (found), or after KEY_LAST fails (fail).
// PARAMETERS
//  KEY_W     24         candidate key width
//  KEY_START 24'h000000 first candidate tried
//  KEY_LAST  24'h3FFFFF last candidate tried; top 2 key bits are always 0
//  MSG_LEN   32         decrypted bytes checked, addresses 0..MSG_LEN-1
//  ADDR_W    8          decrypted-memory address width
// PORTS
//  clk       in   1       system clock (CLOCK_50 domain)
//  reset     in   1       asynchronous, active-high reset
//  start     in   1       begin search from KEY_START; sampled in IDLE/FOUND/FAIL only
//  dp_done   in   1       datapath finished decrypting current key; level or pulse
//  d_q       in   8       decrypted-memory read data, valid 1 cycle after d_addr
//  key_out   out  KEY_W   candidate key to datapath secret_key
//  dp_start  out  1       one-cycle pulse: datapath starts a decrypt with key_out
//  d_addr    out  ADDR_W  decrypted-memory read address
//  d_sel     out  1       1 = this block owns the decrypted-memory address mux (top-level muxes on it)
//  busy      out  1       search in progress
//  found     out  1       sticky: key_out holds the valid key
//  fail      out  1       sticky: key space exhausted
// BEHAVIOUR
//  Reset values: state IDLE, key_out=KEY_START, dp_start=0, d_addr=0, d_sel=0, busy=0, found=0, fail=0.
//  States:
//   IDLE:   start -> LAUNCH with key_out=KEY_START.
//   LAUNCH: dp_start=1 for exactly 1 cycle -> WAIT_DP. dp_done is ignored in this cycle.
//   WAIT_DP: stays until dp_done=1 -> SCAN with d_addr=0, d_sel=1.
//   SCAN:   pipelined scan. One address is issued per cycle (d_addr increments).
//           The byte for address n is compared on the cycle after n is issued.
//   NEXT:   if key_out==KEY_LAST -> FAIL; else key_out+1 -> LAUNCH.
//   FOUND/FAIL: hold all outputs; start -> clear found/fail, key_out=KEY_START, go to LAUNCH.
//  Scan rules:
//   Byte valid iff 8'h61<=d_q<=8'h7A or d_q==8'h20.
//   First invalid byte aborts the scan -> NEXT; any read already issued is discarded.
//   All MSG_LEN bytes valid -> FOUND with found=1 and key_out unchanged.
//   A fully valid scan takes MSG_LEN+1 cycles.
//   d_addr never exceeds MSG_LEN-1. d_sel=1 only in SCAN and drops on the exit cycle.
//  busy=1 in LAUNCH, WAIT_DP, SCAN and NEXT.
//  key_out is stable from LAUNCH until the next NEXT; it never changes while the datapath is running.
//  start while busy is ignored.
//  KEY_START==KEY_LAST is legal: exactly one candidate is tried.
//  Async reset in any state, including mid-WAIT_DP or mid-SCAN, returns all outputs to reset values at once.
//  No dp_start pulse is issued until a new start.
// STRUCTURE
//  Package ksa_search_pkg holds:
//   - state enum (IDLE, LAUNCH, WAIT_DP, SCAN, NEXT, FOUND, FAIL)
//   - constants ASCII_LO=8'h61, ASCII_HI=8'h7A, ASCII_SP=8'h20
//  One sub-module, ascii_byte_checker: 8-bit in -> valid bit, purely combinational.
//  The FSM, key counter and scan address counter stay in key_search_ctrl.
// TESTING (bench models datapath: dp_done 5 cycles after dp_start; d_q from a key-indexed byte table)
//  1. Reset -> all outputs at reset values; no dp_start for 20 cycles with start=0.
//  2. KEY_START=24'h000247; table valid only for key 24'h000249; start ->
//     3 dp_start pulses, then found=1, key_out=24'h000249, busy=0.
//  3. Boundary bytes at address 0: 8'h60 or 8'h7B -> NEXT after one compare;
//     8'h20, 8'h61 and 8'h7A pass; bad byte at address 31 -> NEXT.
//  4. KEY_START=KEY_LAST-1, table never valid -> 2 launches, then fail=1, key_out=KEY_LAST.
//  5. Async reset asserted mid-WAIT_DP and mid-SCAN -> immediate IDLE, d_sel=0, busy=0.
//  6. start pulsed during WAIT_DP -> ignored; start in FOUND -> found clears, search restarts at KEY_START.

Source files
------------

// File: rtl/ksa_search_pkg.sv
// Shared types and constants for the RC4 brute-force key search controller.
package ksa_search_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_DP = 3'd2,
    SCAN    = 3'd3,
    NEXT    = 3'd4,
    FOUND   = 3'd5,
    FAIL    = 3'd6
  } state_e;

  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  localparam logic [7:0] ASCII_SP = 8'h20;

endpackage

// File: rtl/ascii_byte_checker.sv
// Flags a decrypted byte as plaintext: lowercase letter or space.
module ascii_byte_checker
  import ksa_search_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       valid_c
);

  assign valid_c = ((byte_in >= ASCII_LO) && (byte_in <= ASCII_HI)) || (byte_in == ASCII_SP);

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force RC4 key search: launch a decrypt per candidate key, then scan the
// decrypted message for printable bytes; stop on the first passing key or when exhausted.
module key_search_ctrl
  import ksa_search_pkg::*;
#(
  parameter int unsigned             KEY_W     = 24,
  parameter logic [KEY_W-1:0]        KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0]        KEY_LAST  = 24'h3FFFFF,
  parameter int unsigned             MSG_LEN   = 32,
  parameter int unsigned             ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dp_done,
  input  logic [7:0]        d_q,
  output logic [KEY_W-1:0]  key_out,
  output logic              dp_start,
  output logic [ADDR_W-1:0] d_addr,
  output logic              d_sel,
  output logic              busy,
  output logic              found,
  output logic              fail
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rd_pend_q, rd_pend_d;   // d_q carries the byte issued last cycle
  logic               last_iss_q, last_iss_d; // final address already issued
  logic               dp_start_q, dp_start_d;
  logic               d_sel_q, d_sel_d;
  logic               busy_q, busy_d;
  logic               found_q, found_d;
  logic               fail_q, fail_d;
  logic               byte_ok_c;

  ascii_byte_checker u_chk (
    .byte_in (d_q),
    .valid_c (byte_ok_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      key_q      <= KEY_START;
      addr_q     <= '0;
      rd_pend_q  <= 1'b0;
      last_iss_q <= 1'b0;
      dp_start_q <= 1'b0;
      d_sel_q    <= 1'b0;
      busy_q     <= 1'b0;
      found_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      addr_q     <= addr_d;
      rd_pend_q  <= rd_pend_d;
      last_iss_q <= last_iss_d;
      dp_start_q <= dp_start_d;
      d_sel_q    <= d_sel_d;
      busy_q     <= busy_d;
      found_q    <= found_d;
      fail_q     <= fail_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FOUND, FAIL: if (start) state_d = LAUNCH;
      LAUNCH:            state_d = WAIT_DP;
      WAIT_DP:           if (dp_done) state_d = SCAN;
      SCAN: begin
        if (rd_pend_q) begin
          if (!byte_ok_c)      state_d = NEXT;
          else if (last_iss_q) state_d = FOUND;
        end
      end
      NEXT:              state_d = (key_q == KEY_LAST) ? FAIL : LAUNCH;
      default:           state_d = IDLE;
    endcase
  end

  // Output / datapath logic: outputs are decoded from the next state so they register aligned with it
  always_comb begin
    key_d      = key_q;
    addr_d     = addr_q;
    rd_pend_d  = 1'b0;
    last_iss_d = last_iss_q;

    if ((state_q == IDLE || state_q == FOUND || state_q == FAIL) && state_d == LAUNCH)
      key_d = KEY_START;
    if (state_q == NEXT && state_d == LAUNCH)
      key_d = key_q + KEY_W'(1);

    if (state_q == WAIT_DP && state_d == SCAN) begin
      addr_d     = '0;
      last_iss_d = 1'b0;
    end

    // Issue the presented address; hold on the last one so d_addr never runs past the message
    if (state_q == SCAN && state_d == SCAN && !last_iss_q) begin
      rd_pend_d = 1'b1;
      if (addr_q == LAST_ADDR) last_iss_d = 1'b1;
      else                     addr_d     = addr_q + ADDR_W'(1);
    end

    dp_start_d = (state_d == LAUNCH);
    d_sel_d    = (state_d == SCAN);
    busy_d     = (state_d == LAUNCH) || (state_d == WAIT_DP) ||
                 (state_d == SCAN)   || (state_d == NEXT);
    found_d    = (state_d == FOUND);
    fail_d     = (state_d == FAIL);
  end

  assign key_out  = key_q;
  assign dp_start = dp_start_q;
  assign d_addr   = addr_q;
  assign d_sel    = d_sel_q;
  assign busy     = busy_q;
  assign found    = found_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: two instances (different KEY_START) with a
// datapath model (dp_done 5 cycles after dp_start) and a key-indexed decrypted-byte table.
module tb_key_search_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start    [2];
  logic        dp_done  [2];
  logic [7:0]  d_q      [2];
  logic [23:0] key_out  [2];
  logic        dp_start [2];
  logic [7:0]  d_addr   [2];
  logic        d_sel    [2];
  logic        busy     [2];
  logic        found    [2];
  logic        fail     [2];

  logic [4:0]  sr       [2];
  logic        prev_dp  [2];
  logic [23:0] k_launch [2];
  int          launches [2];
  int          run_len  [2];
  int          run_cnt  [2];
  int          run_log  [2][8];
  int          dbl      [2];
  int          addr_bad [2];
  int          key_bad  [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    key_search_ctrl #(
      .KEY_START ((g == 0) ? 24'h000247 : 24'h3FFFFE)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start[g]),
      .dp_done  (dp_done[g]),
      .d_q      (d_q[g]),
      .key_out  (key_out[g]),
      .dp_start (dp_start[g]),
      .d_addr   (d_addr[g]),
      .d_sel    (d_sel[g]),
      .busy     (busy[g]),
      .found    (found[g]),
      .fail     (fail[g])
    );
    assign dp_done[g] = sr[g][4];
  end

  function automatic logic [7:0] tbl(input logic [23:0] k, input logic [7:0] a);
    case (k)
      24'h000247: return (a == 8'd0) ? 8'h20 : (a == 8'd31) ? 8'h7B : 8'h61;
      24'h000248: return (a == 8'd0) ? 8'h60 : 8'h61;
      24'h000249: return (a == 8'd0) ? 8'h61 : (a == 8'd1) ? 8'h7A : (a == 8'd2) ? 8'h20 : 8'h6D;
      24'h3FFFFE: return (a == 8'd0) ? 8'h7B : 8'h61;
      24'h3FFFFF: return (a == 8'd5) ? 8'h00 : 8'h62;
      default:    return 8'h00;
    endcase
  endfunction

  // Datapath model: done pulse 5 cycles after dp_start
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sr[0] <= '0;
      sr[1] <= '0;
    end else begin
      for (int g = 0; g < 2; g++) sr[g] <= {sr[g][3:0], dp_start[g]};
    end
  end

  // Decrypted memory: one-cycle read latency
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) d_q[g] <= tbl(key_out[g], d_addr[g]);
  end

  // Monitor: launch count, scan lengths (cycles with d_sel high), protocol checks
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (dp_start[g]) begin
        launches[g]++;
        k_launch[g] = key_out[g];
      end
      if (dp_start[g] && prev_dp[g]) dbl[g]++;
      prev_dp[g] = dp_start[g];
      if (busy[g] && !dp_start[g] && key_out[g] !== k_launch[g]) key_bad[g]++;
      if (d_sel[g]) begin
        run_len[g]++;
        if (d_addr[g] > 8'd31) addr_bad[g]++;
      end else if (run_len[g] != 0) begin
        if (run_cnt[g] < 8) run_log[g][run_cnt[g]] = run_len[g];
        run_cnt[g]++;
        run_len[g] = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr(input int g);
    launches[g] = 0;
    run_cnt[g]  = 0;
    run_len[g]  = 0;
  endtask

  task automatic pulse(input int g);
    start[g] = 1'b1;
    step(1);
    start[g] = 1'b0;
  endtask

  task automatic wait_end(input int g, input int budget);
    int i = 0;
    while (!found[g] && !fail[g] && i < budget) begin
      step(1);
      i++;
    end
    check("end_timeout", 32'(found[g] | fail[g]), 32'd1);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      clr(g);
      start[g] = 1'b0; prev_dp[g] = 1'b0; k_launch[g] = '0;
      dbl[g] = 0; addr_bad[g] = 0; key_bad[g] = 0;
    end
    reset = 1'b1;
    step(3);

    // Reset values
    check("rst_key",      32'(key_out[0]),  32'h000247);
    check("rst_key_b",    32'(key_out[1]),  32'h3FFFFE);
    check("rst_dp_start", 32'(dp_start[0]), 32'd0);
    check("rst_d_addr",   32'(d_addr[0]),   32'd0);
    check("rst_d_sel",    32'(d_sel[0]),    32'd0);
    check("rst_busy",     32'(busy[0]),     32'd0);
    check("rst_found",    32'(found[0]),    32'd0);
    check("rst_fail",     32'(fail[0]),     32'd0);
    reset = 1'b0;
    clr(0); clr(1);
    step(20);
    check("idle_launches", 32'(launches[0] + launches[1]), 32'd0);

    // Search from 0x247: bad byte at addr 31, bad at addr 0 (0x60), then valid at 0x249
    clr(0);
    pulse(0);
    wait_end(0, 600);
    step(2);
    check("srch_found",    32'(found[0]),    32'd1);
    check("srch_fail",     32'(fail[0]),     32'd0);
    check("srch_key",      32'(key_out[0]),  32'h000249);
    check("srch_busy",     32'(busy[0]),     32'd0);
    check("srch_d_sel",    32'(d_sel[0]),    32'd0);
    check("srch_launches", 32'(launches[0]), 32'd3);
    check("srch_scans",    32'(run_cnt[0]),  32'd3);
    check("scan_bad31",    32'(run_log[0][0]), 32'd33);
    check("scan_bad0_60",  32'(run_log[0][1]), 32'd2);
    check("scan_full",     32'(run_log[0][2]), 32'd33);
    check("found_d_addr",  32'(d_addr[0]),   32'd31);

    // Exhaustion: 0x3FFFFE (0x7B at addr 0) then KEY_LAST (bad at addr 5)
    clr(1);
    pulse(1);
    wait_end(1, 600);
    step(2);
    check("exh_fail",     32'(fail[1]),     32'd1);
    check("exh_found",    32'(found[1]),    32'd0);
    check("exh_key",      32'(key_out[1]),  32'h3FFFFF);
    check("exh_busy",     32'(busy[1]),     32'd0);
    check("exh_launches", 32'(launches[1]), 32'd2);
    check("exh_scans",    32'(run_cnt[1]),  32'd2);
    check("scan_bad0_7b", 32'(run_log[1][0]), 32'd2);
    check("scan_bad5",    32'(run_log[1][1]), 32'd7);

    // Restart from FOUND; start during WAIT_DP ignored
    clr(0);
    pulse(0);
    check("rs_dp_start", 32'(dp_start[0]), 32'd1);
    check("rs_busy",     32'(busy[0]),     32'd1);
    check("rs_found",    32'(found[0]),    32'd0);
    check("rs_key",      32'(key_out[0]),  32'h000247);
    step(2);
    pulse(0);
    check("wd_start_ign", 32'(dp_start[0]), 32'd0);
    wait_end(0, 600);
    step(2);
    check("rs_found2",   32'(found[0]),    32'd1);
    check("rs_key2",     32'(key_out[0]),  32'h000249);
    check("rs_launches", 32'(launches[0]), 32'd3);

    // Async reset mid-WAIT_DP
    pulse(0);
    step(2);
    check("wd_pre_busy", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("wd_rst_busy",  32'(busy[0]),     32'd0);
    check("wd_rst_d_sel", 32'(d_sel[0]),    32'd0);
    check("wd_rst_dp",    32'(dp_start[0]), 32'd0);
    check("wd_rst_addr",  32'(d_addr[0]),   32'd0);
    check("wd_rst_found", 32'(found[0]),    32'd0);
    step(1);
    reset = 1'b0;
    clr(0);
    step(20);
    check("post_rst_launch", 32'(launches[0]), 32'd0);
    check("post_rst_busy",   32'(busy[0]),     32'd0);

    // Async reset mid-SCAN
    pulse(0);
    begin
      int i = 0;
      while (!d_sel[0] && i < 50) begin
        step(1);
        i++;
      end
    end
    check("sel_timeout", 32'(d_sel[0]), 32'd1);
    step(3);
    check("sc_pre_d_sel", 32'(d_sel[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("sc_rst_d_sel", 32'(d_sel[0]),  32'd0);
    check("sc_rst_busy",  32'(busy[0]),   32'd0);
    check("sc_rst_addr",  32'(d_addr[0]), 32'd0);
    check("sc_rst_key",   32'(key_out[0]), 32'h000247);
    step(1);
    reset = 1'b0;
    step(3);

    // Recovery after reset
    clr(0);
    pulse(0);
    wait_end(0, 600);
    step(2);
    check("rec_found",    32'(found[0]),    32'd1);
    check("rec_key",      32'(key_out[0]),  32'h000249);
    check("rec_launches", 32'(launches[0]), 32'd3);

    for (int g = 0; g < 2; g++) begin
      check("dp_start_1cyc", 32'(dbl[g]),      32'd0);
      check("addr_range",    32'(addr_bad[g]), 32'd0);
      check("key_stable",    32'(key_bad[g]),  32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
